// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
//   Shares the switch/LED peripheral bus between two masters, m0 (CPU data port)
//   and m1 (debug/host port). Round-robin arbitration with one access in flight.
//   Each access takes three cycles: IDLE (arbitrate), ACCESS (grant), RESP (complete).
//   The block owns the LED output register and the switch input synchronizer.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   mX_req/we/addr/wdata        master X request fields, held until mX_gnt
//   mX_gnt                      one-cycle grant; the fields are sampled at the end of this cycle
//   mX_rvalid/rdata             one-cycle completion; rdata is zero whenever rvalid is low
//   sw_in                       raw asynchronous board switches
//   led_out                     LED register value
//   bus_err                     pulses together with rvalid when the address is unmapped
//
// Handshake: a master raises req with stable we/addr/wdata and holds them through
// the cycle in which its gnt is high. The response (rvalid, rdata, bus_err) follows
// in the next cycle. req may drop once gnt has been seen. Requests that arrive
// during ACCESS or RESP wait until the next IDLE cycle.
module io_bus_arbiter #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter logic [ADDR_W-1:0] LED_ADDR = 16'hC000,
    parameter logic [ADDR_W-1:0] SW_ADDR  = 16'hC001,
    parameter int              IO_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic [IO_W-1:0]   sw_in,
    output logic [IO_W-1:0]   led_out,
    output logic              bus_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic              winner_q,  winner_d;   // 0 = m0, 1 = m1
    logic              last_q,    last_d;     // master granted most recently
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              err_q,     err_d;
    logic [IO_W-1:0]   led_q,     led_d;
    logic [IO_W-1:0]   sw_meta_q, sw_meta_d;
    logic [IO_W-1:0]   sw_sync_q, sw_sync_d;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Only the low IO_W bits of write data reach the LED register.
    logic unused_wdata;
    assign unused_wdata = ^{m0_wdata, m1_wdata};

    assign sel_we    = winner_q ? m1_we    : m0_we;
    assign sel_addr  = winner_q ? m1_addr  : m0_addr;
    assign sel_wdata = winner_q ? m1_wdata : m0_wdata;

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        last_d    = last_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        led_d     = led_q;
        sw_meta_d = sw_in;
        sw_sync_d = sw_meta_q;

        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d = ST_ACCESS;
                    // On a tie the master that was not granted last wins.
                    if (m0_req && m1_req) winner_d = ~last_q;
                    else                  winner_d = m1_req;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                last_d  = winner_q;
                rdata_d = '0;
                err_d   = 1'b0;
                if (sel_addr == LED_ADDR) begin
                    if (sel_we) led_d = sel_wdata[IO_W-1:0];
                    else        rdata_d[IO_W-1:0] = led_q;
                end else if (sel_addr == SW_ADDR) begin
                    // Writes to the switch register are silently dropped.
                    if (!sel_we) rdata_d[IO_W-1:0] = sw_sync_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            winner_q  <= 1'b0;
            last_q    <= 1'b1;   // makes m0 win the first tie
            rdata_q   <= '0;
            err_q     <= 1'b0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            last_q    <= last_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    // Grants and responses are pure decodes of registered state, so there is no
    // combinational path from req to gnt.
    assign m0_gnt    = (state_q == ST_ACCESS) && !winner_q;
    assign m1_gnt    = (state_q == ST_ACCESS) &&  winner_q;
    assign m0_rvalid = (state_q == ST_RESP)   && !winner_q;
    assign m1_rvalid = (state_q == ST_RESP)   &&  winner_q;
    assign m0_rdata  = m0_rvalid ? rdata_q : '0;
    assign m1_rdata  = m1_rvalid ? rdata_q : '0;
    assign bus_err   = (state_q == ST_RESP) && err_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;

  localparam logic [15:0] LED_A = 16'hC000;
  localparam logic [15:0] SW_A  = 16'hC001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [15:0] addr_v  [2];
  logic [15:0] wdata_v [2];
  logic        gnt_v   [2];
  logic        rvalid_v[2];
  logic [15:0] rdata_v [2];
  logic [9:0]  sw_in;
  logic [9:0]  led_out;
  logic        bus_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state
  logic [9:0] led_model;
  logic [9:0] sw_model;
  int         last_model;   // master granted most recently (1 after reset)

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  io_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req_v[0]), .m0_we(we_v[0]), .m0_addr(addr_v[0]), .m0_wdata(wdata_v[0]),
    .m0_gnt(gnt_v[0]), .m0_rvalid(rvalid_v[0]), .m0_rdata(rdata_v[0]),
    .m1_req(req_v[1]), .m1_we(we_v[1]), .m1_addr(addr_v[1]), .m1_wdata(wdata_v[1]),
    .m1_gnt(gnt_v[1]), .m1_rvalid(rvalid_v[1]), .m1_rdata(rdata_v[1]),
    .sw_in(sw_in), .led_out(led_out), .bus_err(bus_err)
  );

  // Expected read data for a completed access, from the register map.
  function automatic logic [15:0] exp_rdata(input logic we, input logic [15:0] addr);
    if (we) return 16'h0000;
    if (addr == LED_A) return {6'd0, led_model};
    if (addr == SW_A)  return {6'd0, sw_model};
    return 16'h0000;
  endfunction

  function automatic logic exp_err(input logic [15:0] addr);
    return (addr != LED_A) && (addr != SW_A);
  endfunction

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0: return LED_A;
      1: return SW_A;
      2: return 16'hC002;
      default: return 16'($urandom_range(0, 16'hBFFF));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic [9:0] v);
    sw_in = v;
    sw_model = v;
    repeat (3) step();
  endtask

  // driver: one access by master m from IDLE, checked against the model
  task automatic do_access(input int m, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input string tag);
    int waited;
    logic [15:0] er;
    logic ee;
    int o;
    o = 1 - m;
    we_v[m] = we; addr_v[m] = addr; wdata_v[m] = wdata; req_v[m] = 1'b1;
    waited = 0;
    step();
    while (!gnt_v[m] && waited < 8) begin
      step();
      waited++;
    end
    total_cnt++;
    if (!gnt_v[m] || waited != 0)
      $display("FAIL %s gnt: got gnt=%0b after %0d extra cycles, required gnt=1 after 0", tag, gnt_v[m], waited);
    else pass_cnt++;
    total_cnt++;
    if (gnt_v[o] !== 1'b0) $display("FAIL %s other_gnt: got %0b, required 0", tag, gnt_v[o]);
    else pass_cnt++;
    last_model = m;
    er = exp_rdata(we, addr);
    ee = exp_err(addr);
    if (we && addr == LED_A) led_model = wdata[9:0];
    step();
    req_v[m] = 1'b0;
    total_cnt++;
    if (rvalid_v[m] !== 1'b1 || rdata_v[m] !== er)
      $display("FAIL %s resp: got rvalid=%0b rdata=%h, required rvalid=1 rdata=%h", tag, rvalid_v[m], rdata_v[m], er);
    else pass_cnt++;
    total_cnt++;
    if (bus_err !== ee) $display("FAIL %s bus_err: got %0b, required %0b", tag, bus_err, ee);
    else pass_cnt++;
    total_cnt++;
    if (rvalid_v[o] !== 1'b0 || rdata_v[o] !== 16'h0 || gnt_v[m] !== 1'b0)
      $display("FAIL %s other_resp: got rvalid=%0b rdata=%h gnt=%0b, required 0 0000 0", tag, rvalid_v[o], rdata_v[o], gnt_v[m]);
    else pass_cnt++;
    total_cnt++;
    if (led_out !== led_model) $display("FAIL %s led: got %h, required %h", tag, led_out, led_model);
    else pass_cnt++;
    step();
    total_cnt++;
    if (rvalid_v[m] !== 1'b0 || rdata_v[m] !== 16'h0 || bus_err !== 1'b0)
      $display("FAIL %s idle: got rvalid=%0b rdata=%h bus_err=%0b, required 0 0000 0", tag, rvalid_v[m], rdata_v[m], bus_err);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (led_out !== 10'h0 || gnt_v[0] !== 1'b0 || gnt_v[1] !== 1'b0 || rvalid_v[0] !== 1'b0 ||
        rvalid_v[1] !== 1'b0 || bus_err !== 1'b0 || rdata_v[0] !== 16'h0 || rdata_v[1] !== 16'h0)
      $display("FAIL reset: got led=%h gnt=%0b%0b rvalid=%0b%0b err=%0b rdata=%h/%h, required all zero",
               led_out, gnt_v[1], gnt_v[0], rvalid_v[1], rvalid_v[0], bus_err, rdata_v[0], rdata_v[1]);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    led_model = '0;
    last_model = 1;
    step();
  endtask

  task automatic test_led_rw();
    do_access(0, 1'b1, LED_A, 16'h03FF, "led_write");
    do_access(0, 1'b0, LED_A, 16'h0000, "led_read");
  endtask

  task automatic test_sw_read();
    set_sw(10'h002);
    do_access(1, 1'b0, SW_A, 16'h0000, "sw_read");
  endtask

  task automatic test_fairness();
    int grants;
    int cyc;
    int prev_cyc;
    int both_seen;
    int exp_m;
    int got_m;
    test_reset();
    for (int m = 0; m < 2; m++) begin
      we_v[m] = 1'b0; addr_v[m] = LED_A; wdata_v[m] = '0; req_v[m] = 1'b1;
    end
    grants = 0; cyc = 0; prev_cyc = 0; both_seen = 0;
    while (grants < 4 && cyc < 20) begin
      step();
      cyc++;
      if ((gnt_v[0] && gnt_v[1]) || (rvalid_v[0] && rvalid_v[1])) both_seen++;
      if (gnt_v[0] || gnt_v[1]) begin
        exp_m = 1 - last_model;
        got_m = gnt_v[1] ? 1 : 0;
        total_cnt++;
        if (got_m != exp_m) $display("FAIL fair_order%0d: got m%0d, required m%0d", grants, got_m, exp_m);
        else pass_cnt++;
        if (grants > 0) begin
          total_cnt++;
          if (cyc - prev_cyc != 3)
            $display("FAIL fair_spacing%0d: got %0d cycles, required 3", grants, cyc - prev_cyc);
          else pass_cnt++;
        end
        last_model = exp_m;
        prev_cyc = cyc;
        grants++;
      end
    end
    total_cnt++;
    if (grants != 4) $display("FAIL fair_count: got %0d grants, required 4", grants);
    else pass_cnt++;
    step();
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    step();
    total_cnt++;
    if (both_seen != 0) $display("FAIL fair_exclusive: got %0d overlaps, required 0", both_seen);
    else pass_cnt++;
  endtask

  task automatic test_bus_err();
    do_access(0, 1'b0, 16'h1234, 16'h0000, "err_read");
    do_access(0, 1'b1, 16'h1234, 16'h0155, "err_write");
    do_access(1, 1'b1, SW_A, 16'h03AA, "sw_write_ignored");
  endtask

  task automatic test_random_single(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) set_sw(10'($urandom));
      do_access(int'($urandom_range(0, 1)), 1'($urandom), rand_addr(), 16'($urandom), "rand_single");
    end
  endtask

  // Both masters may contend; the winner follows the round-robin rule.
  task automatic test_random_contention(input int n);
    int pat;
    int w;
    logic [15:0] er;
    logic ee;
    for (int i = 0; i < n; i++) begin
      pat = int'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++) begin
        we_v[m] = 1'($urandom); addr_v[m] = rand_addr(); wdata_v[m] = 16'($urandom);
        req_v[m] = pat[m];
      end
      if (pat == 3) w = 1 - last_model;
      else          w = (pat == 2) ? 1 : 0;
      step();
      total_cnt++;
      if (gnt_v[w] !== 1'b1 || gnt_v[1-w] !== 1'b0)
        $display("FAIL cont_gnt%0d: got gnt=%0b%0b, required winner m%0d", i, gnt_v[1], gnt_v[0], w);
      else pass_cnt++;
      er = exp_rdata(we_v[w], addr_v[w]);
      ee = exp_err(addr_v[w]);
      if (we_v[w] && addr_v[w] == LED_A) led_model = wdata_v[w][9:0];
      last_model = w;
      step();
      req_v[0] = 1'b0; req_v[1] = 1'b0;
      total_cnt++;
      if (rvalid_v[w] !== 1'b1 || rdata_v[w] !== er || rvalid_v[1-w] !== 1'b0 || bus_err !== ee ||
          led_out !== led_model)
        $display("FAIL cont_resp%0d: got rvalid=%0b%0b rdata=%h err=%0b led=%h, required winner m%0d rdata=%h err=%0b led=%h",
                 i, rvalid_v[1], rvalid_v[0], rdata_v[w], bus_err, led_out, w, er, ee, led_model);
      else pass_cnt++;
      step();
    end
  endtask

  task automatic test_reset_mid();
    we_v[0] = 1'b1; addr_v[0] = LED_A; wdata_v[0] = 16'h0001; req_v[0] = 1'b1;
    // prior value must differ from the write so a leaked commit is visible
    do_access(1, 1'b1, LED_A, 16'h0000, "mid_pre");
    req_v[0] = 1'b1;
    step();
    total_cnt++;
    if (gnt_v[0] !== 1'b1) $display("FAIL mid_gnt: got %0b, required 1", gnt_v[0]);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (gnt_v[0] !== 1'b0 || rvalid_v[0] !== 1'b0) $display("FAIL mid_async: got gnt=%0b rvalid=%0b, required 0 0", gnt_v[0], rvalid_v[0]);
    else pass_cnt++;
    req_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    led_model = '0;
    last_model = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      total_cnt++;
      if (rvalid_v[0] !== 1'b0 || gnt_v[0] !== 1'b0 || led_out !== 10'h0)
        $display("FAIL mid_after%0d: got rvalid=%0b gnt=%0b led=%h, required 0 0 000", c, rvalid_v[0], gnt_v[0], led_out);
      else pass_cnt++;
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 1'b0; we_v[m] = 1'b0; addr_v[m] = '0; wdata_v[m] = '0;
    end
    sw_in = '0;
    sw_model = '0;
    led_model = '0;
    last_model = 1;
    test_reset();
    test_led_rw();
    test_sw_read();
    test_fairness();
    test_bus_err();
    test_random_single(30);
    test_random_contention(40);
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
